bcd_serial_add_ctrl: RTL and testbench
======================================

// Module: bcd_serial_add_ctrl
// PURPOSE
//   Sequencer that time-shares one single-digit BCD add datapath (4b+4b+cin, decimal correct) across
//   DIGITS digit positions, LSD first, one digit per clock. Latches packed multi-digit BCD operands on
//   start, ripples decimal carry between digits, validates every digit, reports sum/cout/error with done.
//   Sits between operand source (switches/regs) and 7-seg display decoders.
// PARAMETERS
//   DIGITS   2   number of BCD digits per operand; legal range >= 1
// PORTS
//   clk     in   1          system clock, rising edge
//   rst_n   in   1          asynchronous, active-low reset
//   start   in   1          request; sampled only in IDLE
//   a       in   4*DIGITS   operand A, packed BCD, digit i = a[4i+3:4i]
//   b       in   4*DIGITS   operand B, packed BCD
//   cin     in   1          carry into digit 0
//   busy    out  1          1 while digits are being processed (RUN)
//   done    out  1          one-cycle pulse: sum/cout/error valid
//   sum     out  4*DIGITS   packed BCD result
//   cout    out  1          decimal carry out of MSD
//   error   out  1          1 = an operand digit > 9 was found
// BEHAVIOUR
//   Clock/reset: one clock; reset is asynchronous and active-low. rst_n=0 forces immediately:
//     state=IDLE, busy=0, done=0, sum=0, cout=0, error=0, digit index=0.
//     Reset mid-operation aborts with no partial result kept.
//   FSM: IDLE -> RUN -> DONE -> IDLE.
//   IDLE: start=1 at edge: latch a,b -> opA,opB; carry<=cin; idx<=0; sum<=0; cout<=0; error<=0; -> RUN.
//   RUN (busy=1), per cycle on digit idx:
//     da=opA[idx], db=opB[idx]; t = da+db+carry (5 bits, 0..19).
//     t>9: digit=(t+6)[3:0], carry_n=1; else digit=t[3:0], carry_n=0.
//     If da>9 or db>9: error<=1, sum<=0, cout<=0, -> DONE (abort; remaining digits skipped).
//     Else sum[idx]<=digit, carry<=carry_n.
//       If idx==DIGITS-1: cout<=carry_n, -> DONE; else idx<=idx+1.
//   DONE: done=1 for exactly one cycle, busy=0; -> IDLE.
//   Timing: start sampled at end of cycle 0 -> busy=1 in cycles 1..DIGITS -> done=1 in cycle DIGITS+1.
//     Abort on digit j: done=1 in cycle j+2.
//   sum/cout/error hold their values from done until the next accepted start (cleared on accept).
//   start while busy or in DONE: ignored, not queued. a/b/cin changes after accept: no effect.
//   start held high continuously: new op accepted in first IDLE cycle after done,
//     i.e. one done pulse every DIGITS+2 cycles.
//   Invalid digit codes 0xA..0xF are the only error source; a sum that carries out is not an error.
// TESTING (DIGITS=2; cycle 0 = start sampled)
//   1 a=0x47 b=0x38 cin=0 -> busy cycles 1-2, done cycle 3, sum=0x85 cout=0 error=0
//   2 a=0x99 b=0x99 cin=1 -> sum=0x99 cout=1 error=0; a=0x00 b=0x00 cin=0 -> sum=0x00 cout=0
//   3 a=0x3A b=0x12 -> done cycle 2, error=1 sum=0 cout=0; a=0xA3 b=0x01 -> done cycle 3, error=1 sum=0
//   4 accept a=0x25 b=0x25, then start=1 and a=0x99 during cycles 1-3 -> single done, sum=0x50, no extra op
//   5 rst_n=0 in cycle 1 of op -> busy/done/sum/cout/error=0 at once; after release a=0x11 b=0x22 -> sum=0x33
//   6 start held high, a=0x19 b=0x01 -> done in cycles 3,7,11..., sum=0x20 each time, busy=0 in IDLE cycles

Source files
------------

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial BCD adder: one shared single-digit decimal adder walks the operands LSD first,
// rippling the decimal carry and aborting with error on any non-BCD operand digit.
module bcd_serial_add_ctrl #(
   parameter int DIGITS = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   input  logic [4*DIGITS-1:0]   a_i,
   input  logic [4*DIGITS-1:0]   b_i,
   input  logic                  cin_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [4*DIGITS-1:0]   sum_o,
   output logic                  cout_o,
   output logic                  error_o
);

   localparam int W     = 4 * DIGITS;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [W-1:0]       opA_q, opA_d;
   logic [W-1:0]       opB_q, opB_d;
   logic [W-1:0]       sum_q, sum_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               carry_q, carry_d;
   logic               cout_q, cout_d;
   logic               error_q, error_d;

   logic [3:0]         digitA;
   logic [3:0]         digitB;
   logic [4:0]         rawSum;
   logic               carryN;
   logic [3:0]         digitSum;
   logic               badDigit;

   always_comb begin
      digitA = 4'd0;
      digitB = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            digitA = opA_q[4*i +: 4];
            digitB = opB_q[4*i +: 4];
         end
      end
   end

   // Decimal correction: adding 6 to a binary 10..19 wraps the low nibble onto 0..9.
   always_comb begin
      rawSum   = {1'b0, digitA} + {1'b0, digitB} + {4'd0, carry_q};
      carryN   = (rawSum > 5'd9);
      digitSum = carryN ? (rawSum[3:0] + 4'd6) : rawSum[3:0];
      badDigit = (digitA > 4'd9) || (digitB > 4'd9);
   end

   always_comb begin
      state_d = state_q;
      opA_d   = opA_q;
      opB_d   = opB_q;
      sum_d   = sum_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      error_d = error_q;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               opA_d   = a_i;
               opB_d   = b_i;
               carry_d = cin_i;
               idx_d   = '0;
               sum_d   = '0;
               cout_d  = 1'b0;
               error_d = 1'b0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (badDigit) begin
               error_d = 1'b1;
               sum_d   = '0;
               cout_d  = 1'b0;
               state_d = DONE;
            end else begin
               for (int i = 0; i < DIGITS; i++) begin
                  if (idx_q == IDX_W'(i)) begin
                     sum_d[4*i +: 4] = digitSum;
                  end
               end
               carry_d = carryN;
               if (idx_q == LAST_IDX) begin
                  cout_d  = carryN;
                  state_d = DONE;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         opA_q   <= '0;
         opB_q   <= '0;
         sum_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         opA_q   <= opA_d;
         opB_q   <= opB_d;
         sum_q   <= sum_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         error_q <= error_d;
      end
   end

   assign busy_o  = (state_q == RUN);
   assign done_o  = (state_q == DONE);
   assign sum_o   = sum_q;
   assign cout_o  = cout_q;
   assign error_o = error_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Scoreboard bench for bcd_serial_add_ctrl (DIGITS=2): a digit-level decimal reference model
// predicts sum/cout/error and the done cycle of every accepted operation.
module tb_bcd_serial_add_ctrl;

   localparam int DIGITS = 2;
   localparam int W      = 4 * DIGITS;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         err;
      int           doneCyc;
   } expect_t;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          cin;
   logic          busy;
   logic          done;
   logic [W-1:0]  sum;
   logic          cout;
   logic          error;

   int            checks;
   int            errors;
   int            cyc;
   expect_t       sb[$];
   logic [W-1:0]  lastSum;

   bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (start),
      .a_i     (a),
      .b_i     (b),
      .cin_i   (cin),
      .busy_o  (busy),
      .done_o  (done),
      .sum_o   (sum),
      .cout_o  (cout),
      .error_o (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, observed, expected, cyc);
      end
   endtask

   // Reference model: decimal add digit by digit, abort on the first non-BCD digit.
   function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc,
                                 output logic [W-1:0] ms, output logic mco, output logic merr,
                                 output int lat);
      int carry;
      int da;
      int db;
      int t;
      carry = int'(mc);
      ms    = '0;
      mco   = 1'b0;
      merr  = 1'b0;
      lat   = DIGITS + 1;
      for (int i = 0; i < DIGITS; i++) begin
         da = int'(ma[4*i +: 4]);
         db = int'(mb[4*i +: 4]);
         if (da > 9 || db > 9) begin
            ms   = '0;
            mco  = 1'b0;
            merr = 1'b1;
            lat  = i + 2;
            return;
         end
         t = da + db + carry;
         if (t >= 10) begin
            t     = t - 10;
            carry = 1;
         end else begin
            carry = 0;
         end
         ms[4*i +: 4] = 4'(t);
      end
      mco = (carry != 0);
   endfunction

   task automatic pushExpect(input logic [W-1:0] ea, input logic [W-1:0] eb, input logic ec);
      expect_t e;
      int      lat;
      model(ea, eb, ec, e.sum, e.cout, e.err, lat);
      e.doneCyc = cyc + lat;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      if (rst_n && done) begin
         if (sb.size() == 0) begin
            checkOutput("spuriousDone", 32'(done), 32'd0);
         end else begin
            expect_t e;
            e = sb.pop_front();
            checkOutput("doneCycle", 32'(cyc), 32'(e.doneCyc));
            checkOutput("sum", 32'(sum), 32'(e.sum));
            checkOutput("cout", 32'(cout), 32'(e.cout));
            checkOutput("error", 32'(error), 32'(e.err));
            checkOutput("busyAtDone", 32'(busy), 32'd0);
            lastSum = sum;
         end
      end
   end

   task automatic waitDone();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done) return;
      end
      checkOutput("doneTimeout", 32'd0, 32'd1);
   endtask

   // Drives one operation from IDLE, scrambles inputs after accept, then checks results hold.
   task automatic applyStimulus(input logic [W-1:0] sa, input logic [W-1:0] sb_, input logic sc);
      @(negedge clk);
      a     = sa;
      b     = sb_;
      cin   = sc;
      start = 1'b1;
      pushExpect(sa, sb_, sc);
      @(negedge clk);
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      cin   = 1'($urandom);
      checkOutput("busyRun", 32'(busy), 32'd1);
      waitDone();
      @(negedge clk);
      checkOutput("busyIdle", 32'(busy), 32'd0);
      checkOutput("sumHold", 32'(sum), 32'(lastSum));
   endtask

   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      checks  = 0;
      errors  = 0;
      cyc     = 0;
      lastSum = '0;
      rst_n   = 1'b0;
      start   = 1'b0;
      a       = '0;
      b       = '0;
      cin     = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("rstBusy", 32'(busy), 32'd0);
      checkOutput("rstDone", 32'(done), 32'd0);
      checkOutput("rstSum", 32'(sum), 32'd0);
      checkOutput("rstCout", 32'(cout), 32'd0);
      checkOutput("rstError", 32'(error), 32'd0);
      rst_n = 1'b1;

      applyStimulus(8'h47, 8'h38, 1'b0);
      applyStimulus(8'h99, 8'h99, 1'b1);
      applyStimulus(8'h00, 8'h00, 1'b0);
      applyStimulus(8'h3A, 8'h12, 1'b0);
      applyStimulus(8'hA3, 8'h01, 1'b0);
      applyStimulus(8'h05, 8'h95, 1'b0);

      // start held during RUN/DONE must not queue a second operation
      @(negedge clk);
      a     = 8'h25;
      b     = 8'h25;
      cin   = 1'b0;
      start = 1'b1;
      pushExpect(8'h25, 8'h25, 1'b0);
      @(negedge clk);
      a = 8'h99;
      waitDone();
      @(negedge clk);
      start = 1'b0;
      checkOutput("noRequeueBusy", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      checkOutput("noRequeueIdle", 32'(busy), 32'd0);

      // asynchronous reset mid-operation, in the first and in the second digit cycle
      for (int rc = 1; rc <= 2; rc++) begin
         @(negedge clk);
         a     = 8'h58;
         b     = 8'h47;
         start = 1'b1;
         pushExpect(8'h58, 8'h47, 1'b0);
         @(negedge clk);
         start = 1'b0;
         if (rc == 2) @(negedge clk);
         #1;
         rst_n = 1'b0;
         #1;
         sb.delete();
         checkOutput("midRstBusy", 32'(busy), 32'd0);
         checkOutput("midRstDone", 32'(done), 32'd0);
         checkOutput("midRstSum", 32'(sum), 32'd0);
         checkOutput("midRstCout", 32'(cout), 32'd0);
         checkOutput("midRstError", 32'(error), 32'd0);
         lastSum = '0;
         repeat (2) @(negedge clk);
         rst_n = 1'b1;
         applyStimulus(8'h11, 8'h22, 1'b0);
      end

      // start held continuously: one accept every DIGITS+2 cycles
      @(negedge clk);
      a     = 8'h19;
      b     = 8'h01;
      cin   = 1'b0;
      start = 1'b1;
      for (int k = 0; k < 3; k++) begin
         checkOutput("heldIdleBusy", 32'(busy), 32'd0);
         pushExpect(8'h19, 8'h01, 1'b0);
         repeat (DIGITS + 2) @(negedge clk);
      end
      start = 1'b0;
      repeat (6) @(negedge clk);

      for (int r = 0; r < 8; r++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         if (r < 5) begin
            ra = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            rb = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
         end
         applyStimulus(ra, rb, 1'($urandom));
      end

      checkOutput("sbEmpty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
